// File: rtl/control_unit.sv
// control_unit: Moore fetch/decode/execute sequencer driving the DataPath control strobes.
// Define CU_MUL_DIV_EN to execute mul/div; without it those opcodes behave as nop.
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        ZHighIn,
    output logic        ZLowIn,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        CONin,
    output logic [4:0]  opcode,
    output logic        Run,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_RTYPE, C_ADDI, C_BR, C_MULDIV, C_HALT, C_NOP
    } iclass_t;

    localparam logic [4:0] OP_ADD = 5'b00011;

    state_t     state;
    state_t     state_nx;
    logic [4:0] op_q;
    iclass_t    cls_q;
    iclass_t    cls_ir;
    logic       last;
    logic       unused_ir;

    function automatic iclass_t decode(input logic [4:0] op);
        case (op)
            5'b00000: return C_LD;
            5'b00001: return C_LDI;
            5'b00010: return C_ST;
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return C_RTYPE;
            5'b01100: return C_ADDI;
            5'b10010: return C_BR;
            5'b11011: return C_HALT;
`ifdef CU_MUL_DIV_EN
            5'b01111, 5'b10000: return C_MULDIV;
`endif
            default: return C_NOP;
        endcase
    endfunction

    // IR is decoded directly in T2; from T3 on the opcode captured at the end of T2 is used.
    assign cls_ir    = decode(IR[31:27]);
    assign cls_q     = decode(op_q);
    assign state_dbg = state;
    assign unused_ir = ^IR[26:0];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_RESET;
            op_q  <= 5'b00000;
        end else begin
            state <= state_nx;
            if (state == S_T2) op_q <= IR[31:27];
        end
    end

    always_comb begin
        state_nx = state;
        last     = 1'b0;
        case (state)
            S_RESET: state_nx = S_T0;
            S_T0:    state_nx = S_T1;
            S_T1:    state_nx = S_T2;
            S_T2: begin
                if (cls_ir == C_HALT)     state_nx = S_HALT;
                else if (cls_ir == C_NOP) last     = 1'b1;
                else                      state_nx = S_T3;
            end
            S_T3:    state_nx = S_T4;
            S_T4:    state_nx = S_T5;
            S_T5: begin
                if (cls_q == C_LDI || cls_q == C_RTYPE || cls_q == C_ADDI) last = 1'b1;
                else state_nx = S_T6;
            end
            S_T6: begin
                if (cls_q == C_BR || cls_q == C_MULDIV) last = 1'b1;
                else state_nx = S_T7;
            end
            S_T7:    last     = 1'b1;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_RESET;
        endcase
        // Stop is only honoured on the final cycle of an instruction.
        if (last) state_nx = Stop ? S_HALT : S_T0;
    end

    always_comb begin
        PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
        MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; ZHighIn = 1'b0; ZLowIn = 1'b0; HIin = 1'b0;
        LOin = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0;
        Rout = 1'b0; BAout = 1'b0; Cout = 1'b0; CONin = 1'b0;
        opcode = 5'b00000;
        Run    = (state != S_HALT);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (cls_q)
                    C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_RTYPE, C_ADDI, C_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_BR: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls_q)
                    C_LD, C_LDI, C_ST, C_ADDI: begin Cout = 1'b1; ZLowIn = 1'b1; opcode = OP_ADD; end
                    C_RTYPE: begin Grc = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; opcode = op_q; end
                    C_MULDIV: begin
                        Grc = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; opcode = op_q;
                    end
                    C_BR: begin PCout = 1'b1; Yin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls_q)
                    C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
                    C_LDI, C_RTYPE, C_ADDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_BR: begin Cout = 1'b1; ZLowIn = 1'b1; opcode = OP_ADD; end
                    C_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls_q)
                    C_LD: begin Read = 1'b1; MDRin = 1'b1; end
                    C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    C_BR: begin Zlowout = 1'b1; PCin = CON_FF; end
                    C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls_q)
                    C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_ST: Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table vectors, directed multi-cycle sequences and randomized
// instruction streams checked against a per-instruction timeline model.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] IR = 32'd0;
    logic        CON_FF = 1'b0;
    logic        Stop = 1'b0;
    logic PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin;
    logic Yin, ZHighIn, ZLowIn, HIin, LOin, IncPC, Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin;
    logic [4:0]  opcode;
    logic        Run;
    logic [3:0]  state_dbg;
    logic [29:0] obs;

    int n_cmp = 0;
    int n_bad = 0;
    logic [29:0] exp_q[$];

    control_unit dut (
        .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .HIin(HIin),
        .LOin(LOin), .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .Cout(Cout), .CONin(CONin),
        .opcode(opcode), .Run(Run), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    assign obs = {Run, opcode, CONin, Cout, BAout, Rout, Rin, Grc, Grb, Gra,
                  Write, Read, IncPC, LOin, HIin, ZLowIn, ZHighIn, Yin,
                  IRin, MDRin, PCin, MARin, MDRout, Zlowout, Zhighout, PCout};

    localparam logic [29:0] PCOUT    = 30'd1 << 0;
    localparam logic [29:0] ZHIGHOUT = 30'd1 << 1;
    localparam logic [29:0] ZLOWOUT  = 30'd1 << 2;
    localparam logic [29:0] MDROUT   = 30'd1 << 3;
    localparam logic [29:0] MARIN    = 30'd1 << 4;
    localparam logic [29:0] PCIN     = 30'd1 << 5;
    localparam logic [29:0] MDRIN    = 30'd1 << 6;
    localparam logic [29:0] IRIN     = 30'd1 << 7;
    localparam logic [29:0] YIN      = 30'd1 << 8;
    localparam logic [29:0] ZHIGHIN  = 30'd1 << 9;
    localparam logic [29:0] ZLOWIN   = 30'd1 << 10;
    localparam logic [29:0] HIIN     = 30'd1 << 11;
    localparam logic [29:0] LOIN     = 30'd1 << 12;
    localparam logic [29:0] INCPC    = 30'd1 << 13;
    localparam logic [29:0] READ     = 30'd1 << 14;
    localparam logic [29:0] WRITE    = 30'd1 << 15;
    localparam logic [29:0] GRA      = 30'd1 << 16;
    localparam logic [29:0] GRB      = 30'd1 << 17;
    localparam logic [29:0] GRC      = 30'd1 << 18;
    localparam logic [29:0] RIN      = 30'd1 << 19;
    localparam logic [29:0] ROUT     = 30'd1 << 20;
    localparam logic [29:0] BAOUT    = 30'd1 << 21;
    localparam logic [29:0] COUT     = 30'd1 << 22;
    localparam logic [29:0] CONIN    = 30'd1 << 23;
    localparam logic [29:0] RUN      = 30'd1 << 29;

    localparam int K_LD = 0, K_LDI = 1, K_ST = 2, K_R = 3, K_ADDI = 4;
    localparam int K_BR = 5, K_MD = 6, K_HALT = 7, K_NOP = 8;

    function automatic logic [29:0] opc(input logic [4:0] o);
        return {1'b0, o, 24'd0};
    endfunction

    function automatic int kind(input logic [4:0] op);
        case (op)
            5'd0: return K_LD;
            5'd1: return K_LDI;
            5'd2: return K_ST;
            5'd3, 5'd4, 5'd5, 5'd6: return K_R;
            5'd12: return K_ADDI;
            5'd18: return K_BR;
            5'd27: return K_HALT;
`ifdef CU_MUL_DIV_EN
            5'd15, 5'd16: return K_MD;
`endif
            default: return K_NOP;
        endcase
    endfunction

    // Cycles per instruction including the three fetch cycles.
    function automatic int inst_len(input logic [4:0] op);
        case (kind(op))
            K_LD, K_ST: return 8;
            K_LDI, K_ADDI, K_R: return 6;
            K_BR, K_MD: return 7;
            default: return 3;
        endcase
    endfunction

    // Expected outputs on cycle k (0 = first fetch cycle) of an instruction.
    function automatic logic [29:0] model(input logic [4:0] op, input logic con, input int k);
        logic [29:0] r;
        r = RUN;
        if (k == 0)      r = r | PCOUT | MARIN | INCPC | ZLOWIN;
        else if (k == 1) r = r | ZLOWOUT | PCIN | READ | MDRIN;
        else if (k == 2) r = r | MDROUT | IRIN;
        else begin
            case (kind(op))
                K_LD, K_ST: begin
                    case (k)
                        3: r = r | GRB | BAOUT | YIN;
                        4: r = r | COUT | ZLOWIN | opc(5'd3);
                        5: r = r | ZLOWOUT | MARIN;
                        6: r = r | ((kind(op) == K_LD) ? (READ | MDRIN) : (GRA | ROUT | MDRIN));
                        7: r = r | ((kind(op) == K_LD) ? (MDROUT | GRA | RIN) : WRITE);
                        default: ;
                    endcase
                end
                K_LDI, K_ADDI: begin
                    case (k)
                        3: r = r | GRB | ((kind(op) == K_LDI) ? BAOUT : ROUT) | YIN;
                        4: r = r | COUT | ZLOWIN | opc(5'd3);
                        5: r = r | ZLOWOUT | GRA | RIN;
                        default: ;
                    endcase
                end
                K_R: begin
                    case (k)
                        3: r = r | GRB | ROUT | YIN;
                        4: r = r | GRC | ROUT | ZLOWIN | opc(op);
                        5: r = r | ZLOWOUT | GRA | RIN;
                        default: ;
                    endcase
                end
                K_BR: begin
                    case (k)
                        3: r = r | GRA | ROUT | CONIN;
                        4: r = r | PCOUT | YIN;
                        5: r = r | COUT | ZLOWIN | opc(5'd3);
                        6: r = r | ZLOWOUT | (con ? PCIN : 30'd0);
                        default: ;
                    endcase
                end
                K_MD: begin
                    case (k)
                        3: r = r | GRB | ROUT | YIN;
                        4: r = r | GRC | ROUT | ZHIGHIN | ZLOWIN | opc(op);
                        5: r = r | ZLOWOUT | LOIN;
                        6: r = r | ZHIGHOUT | HIIN;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [29:0] e);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, obs, e);
        end
    endtask

    // Entered at a negedge with the DUT in T0; leaves at the negedge after the last cycle.
    task automatic run_instr(input logic [31:0] ir, input logic con, input int stop_k,
                             input int chk_k, input logic [29:0] chk_exp, input string nm);
        int len;
        logic [29:0] e;
        len = inst_len(ir[31:27]);
        for (int k = 0; k < len; k++) exp_q.push_back(model(ir[31:27], con, k));
        IR = ir;
        CON_FF = con;
        for (int k = 0; k < len; k++) begin
            e = exp_q.pop_front();
            check($sformatf("%s c%0d", nm, k), e);
            if (k == chk_k) check($sformatf("%s table c%0d", nm, k), chk_exp);
            if (stop_k >= 0 && k >= stop_k) Stop = 1'b1;
            @(negedge clock);
        end
        Stop = 1'b0;
        if (kind(ir[31:27]) == K_HALT || (stop_k >= 0 && stop_k < len))
            check($sformatf("%s halted", nm), 30'd0);
    endtask

    // Asynchronous clear, checked before any clock edge, then released into T0.
    task automatic do_reset(input string nm);
        #1 clear = 1'b0;
        #1 check($sformatf("%s clear async", nm), RUN);
        @(negedge clock);
        check($sformatf("%s clear hold", nm), RUN);
        clear = 1'b1;
        @(negedge clock);
    endtask

    typedef struct {
        logic [31:0] ir;
        logic        con;
        int          k;
        logic [29:0] exp;
    } vec_t;

    vec_t tbl [17];
    logic [4:0] pool [10];

    initial begin
        logic [4:0] op;
        logic [29:0] e;

        tbl[0]  = '{32'h008800B6, 1'b0, 0, RUN | PCOUT | MARIN | INCPC | ZLOWIN};
        tbl[1]  = '{32'h008800B6, 1'b0, 1, RUN | ZLOWOUT | PCIN | READ | MDRIN};
        tbl[2]  = '{32'h109800B6, 1'b0, 4, RUN | opc(5'd3) | COUT | ZLOWIN};
        tbl[3]  = '{32'h109800B6, 1'b0, 6, RUN | GRA | ROUT | MDRIN};
        tbl[4]  = '{32'h109800B6, 1'b0, 7, RUN | WRITE};
        tbl[5]  = '{32'h008800B6, 1'b0, 6, RUN | READ | MDRIN};
        tbl[6]  = '{32'h008800B6, 1'b0, 7, RUN | MDROUT | GRA | RIN};
        tbl[7]  = '{32'h90800005, 1'b0, 6, RUN | ZLOWOUT};
        tbl[8]  = '{32'h90800005, 1'b1, 6, RUN | ZLOWOUT | PCIN};
        tbl[9]  = '{32'h90800005, 1'b1, 3, RUN | GRA | ROUT | CONIN};
        tbl[10] = '{32'h90800005, 1'b0, 5, RUN | opc(5'd3) | COUT | ZLOWIN};
        tbl[11] = '{32'h19180000, 1'b0, 4, RUN | opc(5'd3) | GRC | ROUT | ZLOWIN};
        tbl[12] = '{32'h21180000, 1'b0, 4, RUN | opc(5'd4) | GRC | ROUT | ZLOWIN};
        tbl[13] = '{32'h31180000, 1'b0, 4, RUN | opc(5'd6) | GRC | ROUT | ZLOWIN};
        tbl[14] = '{32'h08800010, 1'b0, 5, RUN | ZLOWOUT | GRA | RIN};
        tbl[15] = '{32'h60800010, 1'b0, 4, RUN | opc(5'd3) | COUT | ZLOWIN};
        tbl[16] = '{32'hD0000000, 1'b0, 2, RUN | MDROUT | IRIN};
        pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd18, 5'd26};

        @(negedge clock);
        do_reset("init");

        for (int i = 0; i < 17; i++)
            run_instr(tbl[i].ir, tbl[i].con, -1, tbl[i].k, tbl[i].exp, $sformatf("vec%0d", i));

        // Stop raised mid-instruction: add completes, then halts.
        run_instr(32'h19180000, 1'b0, 4, 5, RUN | ZLOWOUT | GRA | RIN, "add_stop");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("add_stop hold", 30'd0);
        end
        do_reset("after_stop");

        // Stop held low while ld runs mid-way, then clear during T5.
        for (int k = 0; k < 6; k++) exp_q.push_back(model(5'd0, 1'b0, k));
        IR = 32'h008800B6;
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            check($sformatf("ld_clear c%0d", k), e);
            if (k < 5) @(negedge clock);
        end
        do_reset("ld_t5");
        run_instr(32'h109800B6, 1'b0, -1, 0, RUN | PCOUT | MARIN | INCPC | ZLOWIN, "post_clear");

        // halt instruction: HALT ignores Stop and IR until cleared.
        run_instr(32'hD8000000, 1'b0, -1, -1, 30'd0, "halt");
        for (int i = 0; i < 20; i++) begin
            Stop = 1'($urandom_range(0, 1));
            IR = $urandom;
            @(negedge clock);
            check($sformatf("halt hold %0d", i), 30'd0);
        end
        Stop = 1'b0;
        do_reset("after_halt");

        // Random instruction stream.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) op = pool[$urandom_range(0, 9)];
            else op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), -1, -1, 30'd0,
                      $sformatf("rnd%0d op%0d", i, op));
        end
        // Random stream ends in Stop on a random instruction.
        op = pool[$urandom_range(0, 8)];
        run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), 2, -1, 30'd0, "rnd_stop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
